// File: rtl/mem_arbiter.sv
// Shares one fixed-latency single-ported memory between fetch and data ports; data wins ties. Optional fetch starvation guard: MEMARB_STARVE_GUARD_EN.
// Latency: grant and mem_* are combinational in the IDLE cycle, and rvalid follows LAT cycles later. The next grant comes LAT+1 cycles after a grant.
// Backpressure: one access in flight; requesters hold their request and are stalled until their rvalid.
module mem_arbiter #(
    parameter int LAT        = 1,
    parameter int STREAK_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        stall
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_BUSY   = 1'b1;
    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    if (LAT < 1 || LAT > 15 || STREAK_MAX < 1 || STREAK_MAX > 15) begin : g_bad_param
        $error("mem_arbiter: LAT and STREAK_MAX must be in 1..15");
    end

    typedef struct packed {
        logic        en;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    logic [0:0] state;
    logic       owner;      // 1 = data port owns the outstanding access
    logic       owner_we;
    logic [3:0] cnt;
    logic       idle;
    logic       starve;
    logic       rvalid_any;
    mem_req_t   mreq;

    assign idle  = (state == S_IDLE) && !reset;
    assign d_gnt = idle && d_req && !(i_req && starve);
    assign i_gnt = idle && i_req && !d_gnt;

    always_comb begin
        mreq = '0;
        if (d_gnt) begin
            mreq = '{en: 1'b1, we: d_we, addr: d_addr, wdata: d_wdata};
        end else if (i_gnt) begin
            mreq = '{en: 1'b1, we: 1'b0, addr: i_addr, wdata: 32'd0};
        end
    end

    assign mem_en    = mreq.en;
    assign mem_we    = mreq.we;
    assign mem_addr  = mreq.addr;
    assign mem_wdata = mreq.wdata;

    assign rvalid_any = (state == S_BUSY) && (cnt == 4'd0) && !reset;
    assign i_rvalid   = rvalid_any && !owner;
    assign d_rvalid   = rvalid_any && owner;
    assign i_rdata    = i_rvalid ? mem_rdata : 32'd0;
    assign d_rdata    = (d_rvalid && !owner_we) ? mem_rdata : 32'd0;
    assign stall      = !reset && ((i_req && !i_rvalid) || (d_req && !d_rvalid));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            owner    <= 1'b0;
            owner_we <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (d_gnt || i_gnt) begin
                        state    <= S_BUSY;
                        cnt      <= CNT_INIT;
                        owner    <= d_gnt;
                        owner_we <= d_gnt && d_we;
                    end
                end
                default: begin
                    if (cnt == 4'd0) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
            endcase
        end
    end

`ifdef MEMARB_STARVE_GUARD_EN
    logic [3:0] streak;

    assign starve = (streak == 4'(STREAK_MAX));

    // Counts data grants that overtook a waiting fetch.
    always_ff @(posedge clk) begin
        if (reset || i_gnt || !i_req) begin
            streak <= 4'd0;
        end else if (d_gnt && streak != 4'hF) begin
            streak <= streak + 4'd1;
        end
    end
`else
    assign starve = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle vector table on a LAT=1 instance plus hand sequences (starvation, LAT=3 reset abort).
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        ig;
        logic        irv;
        logic [31:0] ird;
        logic        dg;
        logic        drv;
        logic [31:0] drd;
        logic        men;
        logic        mwe;
        logic [31:0] mad;
        logic [31:0] mwd;
        logic        st;
    } out_t;

    typedef struct packed {
        logic        rst;
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic [31:0] rdata;
        out_t        exp;
    } vec_t;

    // LAT=1 instance
    logic        reset, i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en, mem_we, stall;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;

    mem_arbiter #(.LAT(1), .STREAK_MAX(4)) dut1 (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall(stall)
    );

    // LAT=3 instance
    logic        reset3, i3_req, d3_req, d3_we;
    logic [31:0] i3_addr, d3_addr, d3_wdata, mem3_rdata;
    logic        i3_gnt, i3_rvalid, d3_gnt, d3_rvalid, mem3_en, mem3_we, stall3;
    logic [31:0] i3_rdata, d3_rdata, mem3_addr, mem3_wdata;

    mem_arbiter #(.LAT(3), .STREAK_MAX(4)) dut3 (
        .clk(clk), .reset(reset3),
        .i_req(i3_req), .i_addr(i3_addr), .i_gnt(i3_gnt), .i_rvalid(i3_rvalid), .i_rdata(i3_rdata),
        .d_req(d3_req), .d_we(d3_we), .d_addr(d3_addr), .d_wdata(d3_wdata),
        .d_gnt(d3_gnt), .d_rvalid(d3_rvalid), .d_rdata(d3_rdata),
        .mem_en(mem3_en), .mem_we(mem3_we), .mem_addr(mem3_addr), .mem_wdata(mem3_wdata),
        .mem_rdata(mem3_rdata), .stall(stall3)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_vec(input int idx, input out_t act, input out_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL vec%0d: got %h want %h (ig,irv,ird,dg,drv,drd,men,mwe,mad,mwd,st)", idx, act, exp);
        end
    endtask

    localparam int NV = 15;
    vec_t vecs [NV];
    out_t act;
    logic guard;

    initial begin
`ifdef MEMARB_STARVE_GUARD_EN
        guard = 1'b1;
`else
        guard = 1'b0;
`endif
        //          rst   ireq  iaddr         dreq  dwe   daddr     dwdata        rdata           ig    irv   ird           dg    drv   drd           men   mwe   mad           mwd           st
        vecs[0]  = '{1'b1, 1'b1, 32'h00400004, 1'b1, 1'b0, 32'h1000, 32'h0,        32'hA5A50001, '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b0}};
        vecs[1]  = '{1'b1, 1'b1, 32'h00400004, 1'b1, 1'b0, 32'h1000, 32'h0,        32'hA5A50001, '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b0}};
        vecs[2]  = '{1'b0, 1'b1, 32'h00400004, 1'b1, 1'b0, 32'h1000, 32'h0,        32'hA5A50001, '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h1000,     32'h0,        1'b1}};
        vecs[3]  = '{1'b0, 1'b1, 32'h00400004, 1'b1, 1'b0, 32'h1000, 32'h0,        32'hA5A50001, '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'hA5A50001, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1}};
        vecs[4]  = '{1'b0, 1'b1, 32'h00400004, 1'b0, 1'b0, 32'h0,    32'h0,        32'hA5A50001, '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h00400004, 32'h0,        1'b1}};
        vecs[5]  = '{1'b0, 1'b1, 32'h00400004, 1'b0, 1'b0, 32'h0,    32'h0,        32'hA5A50001, '{1'b0, 1'b1, 32'hA5A50001, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b0}};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,    32'h0,        32'hA5A50001, '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b0}};
        vecs[7]  = '{1'b0, 1'b1, 32'h00400000, 1'b0, 1'b0, 32'h0,    32'h0,        32'hDEADBEEF, '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h00400000, 32'h0,        1'b1}};
        vecs[8]  = '{1'b0, 1'b1, 32'h00400000, 1'b0, 1'b0, 32'h0,    32'h0,        32'hDEADBEEF, '{1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b0}};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h2000, 32'h12345678, 32'hFFFFFFFF, '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h2000,     32'h12345678, 1'b1}};
        vecs[10] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h2000, 32'h12345678, 32'hFFFFFFFF, '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b0}};
        vecs[11] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,    32'h0,        32'hFFFFFFFF, '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b0}};
        vecs[12] = '{1'b0, 1'b1, 32'h00400008, 1'b0, 1'b0, 32'h0,    32'h0,        32'h13572468, '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h00400008, 32'h0,        1'b1}};
        // fetch request withdrawn early: access still completes
        vecs[13] = '{1'b0, 1'b0, 32'h00400008, 1'b0, 1'b0, 32'h0,    32'h0,        32'h13572468, '{1'b0, 1'b1, 32'h13572468, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b0}};
        vecs[14] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,    32'h0,        32'h0,        '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b0}};

        reset = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_rdata = '0;
        reset3 = 1'b1; i3_req = 1'b0; i3_addr = '0; d3_req = 1'b0; d3_we = 1'b0;
        d3_addr = '0; d3_wdata = '0; mem3_rdata = 32'hCAFEF00D;

        for (int v = 0; v < NV; v++) begin
            @(negedge clk);
            reset = vecs[v].rst; i_req = vecs[v].ireq; i_addr = vecs[v].iaddr;
            d_req = vecs[v].dreq; d_we = vecs[v].dwe; d_addr = vecs[v].daddr;
            d_wdata = vecs[v].dwdata; mem_rdata = vecs[v].rdata;
            #1;
            act = '{i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
                    mem_en, mem_we, mem_addr, mem_wdata, stall};
            chk_vec(v, act, vecs[v].exp);
        end

        // Both ports held: guard lets fetch in after STREAK_MAX data grants
        for (int c = 0; c < 20; c++) begin
            logic exp_i, exp_d;
            @(negedge clk);
            i_req = 1'b1; i_addr = 32'h00400010; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4000;
            #1;
            exp_i = guard && (c % 10 == 8);
            exp_d = (c % 2 == 0) && !exp_i;
            chk($sformatf("streak_i_gnt_c%0d", c), {31'd0, i_gnt}, {31'd0, exp_i});
            chk($sformatf("streak_d_gnt_c%0d", c), {31'd0, d_gnt}, {31'd0, exp_d});
        end
        @(negedge clk);
        i_req = 1'b0; d_req = 1'b0;

        // LAT=3: fetch granted, reset aborts it, re-grant right after reset
        @(negedge clk);
        reset3 = 1'b0; i3_req = 1'b1; i3_addr = 32'h00400000;
        #1;
        chk("lat3_gnt0", {31'd0, i3_gnt}, 32'd1);
        @(negedge clk);
        reset3 = 1'b1;
        #1;
        chk("lat3_reset_outs", {26'd0, i3_gnt, i3_rvalid, d3_gnt, d3_rvalid, mem3_en, stall3}, 32'd0);
        @(negedge clk);
        reset3 = 1'b0;
        #1;
        chk("lat3_regnt", {31'd0, i3_gnt}, 32'd1);
        chk("lat3_regnt_addr", mem3_addr, 32'h00400000);
        @(negedge clk);
        d3_req = 1'b1; d3_addr = 32'h3000;
        #1;
        chk("lat3_c3_busy", {28'd0, i3_rvalid, d3_gnt, mem3_en, stall3}, 32'd1);
        @(negedge clk);
        #1;
        chk("lat3_c4_busy", {28'd0, i3_rvalid, d3_gnt, mem3_en, stall3}, 32'd1);
        @(negedge clk);
        #1;
        chk("lat3_c5_rvalid", {29'd0, i3_rvalid, d3_gnt, mem3_en}, 32'd4);
        chk("lat3_c5_rdata", i3_rdata, 32'hCAFEF00D);
        @(negedge clk);
        i3_req = 1'b0;
        #1;
        chk("lat3_d_gnt", {31'd0, d3_gnt}, 32'd1);
        chk("lat3_d_addr", mem3_addr, 32'h3000);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("lat3_d_wait%0d", c), {30'd0, d3_rvalid, d3_rdata != 32'd0}, 32'd0);
        end
        @(negedge clk);
        #1;
        chk("lat3_d_rvalid", {31'd0, d3_rvalid}, 32'd1);
        chk("lat3_d_rdata", d3_rdata, 32'hCAFEF00D);
        @(negedge clk);
        d3_req = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-ported, fixed-latency memory between the MIPS core's instruction-fetch port and data (load/store) port. Sits between the core and the unified memory. Serialises accesses with a one-outstanding-access FSM and returns read data with a valid strobe. Produces a stall signal that freezes the core while either of its requests is unserved.

## Interface
Parameters:
- `LAT`, default 1: memory read latency in cycles from `mem_en` to valid `mem_rdata`; legal range 1..15.
- `STREAK_MAX`, default 4: consecutive data grants allowed while a fetch waits. Used only with the starvation guard.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `i_req` in 1: fetch request; held high with `i_addr` stable until `i_rvalid`.
- `i_addr` in 32: fetch address.
- `i_gnt` out 1: fetch access launched this cycle.
- `i_rvalid` out 1: fetch data valid this cycle.
- `i_rdata` out 32: fetch data; equals `mem_rdata` when `i_rvalid`, else 0.
- `d_req` in 1: data request; held with `d_we`/`d_addr`/`d_wdata` stable until `d_rvalid`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in 32: data address.
- `d_wdata` in 32: store data.
- `d_gnt` out 1: data access launched this cycle.
- `d_rvalid` out 1: load data valid, or store complete, this cycle.
- `d_rdata` out 32: `mem_rdata` when `d_rvalid` and the access is a load, else 0.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 1: memory write enable.
- `mem_addr` out 32: memory address.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: memory read data, valid `LAT` cycles after `mem_en`.
- `stall` out 1: `(i_req & ~i_rvalid) | (d_req & ~d_rvalid)`.

## Operation
- FSM states:
  - IDLE: no access outstanding.
  - BUSY: one access outstanding. Tracks `owner` (I/D), `owner_we`, and a latency counter `cnt`.
- In IDLE, when any request is eligible:
  - Grant exactly one requester; `gnt`, `mem_en`, `mem_we`, `mem_addr` and `mem_wdata` are combinational from the winning port in the same cycle.
  - `mem_we` = `d_we` for a data grant, 0 for a fetch grant.
  - Set `cnt` = `LAT`-1 and go to BUSY.
- In BUSY:
  - `mem_en` is 0 and no grants are issued.
  - `cnt` decrements each cycle.
  - In the cycle `cnt`==0, assert the owner's `rvalid` (registered decode of state/cnt), then return to IDLE.
- Eligibility: a port is not eligible in its own `rvalid` cycle. The earliest re-grant is the next cycle, which is the IDLE cycle.
- Arbitration: data has priority over fetch (a pending load/store blocks the pipeline longer).
- `mem_*` outputs are 0 whenever no grant is issued.
- All `*_rdata` outputs are 0 outside their `rvalid` cycle.

## Timing
- Access occupancy is `LAT`+1 cycles:
  - grant in cycle t;
  - `rvalid` in cycle t+`LAT`;
  - next grant no earlier than t+`LAT`+1.
- Reset:
  - State returns to IDLE; `cnt`, `owner` and `streak` clear to 0.
  - During any cycle with `reset`=1, every output is forced to 0, including `stall`, `gnt` and `mem_en`.
- Reset mid-access: the outstanding access is abandoned and its `rvalid` is never issued. Requesters re-request after reset.
- Simultaneous `i_req` and `d_req` in IDLE: data wins (subject to the starvation guard). Fetch waits with `stall`=1.
- A request that drops before `rvalid` violates the protocol; the arbiter still completes the access and issues `rvalid`.

## Configuration
- `MEMARB_STARVE_GUARD_EN` defined:
  - A 4-bit `streak` counter increments on each data grant made while `i_req`=1.
  - It clears on any fetch grant, or in any cycle with `i_req`=0.
  - When `streak`==`STREAK_MAX` and both ports are eligible, fetch is granted.
- Undefined: strict data priority; no `streak` register is built.

## Test plan
- Reset held 2 cycles with `i_req`=`d_req`=1 -> all outputs 0. First grant is `d_gnt` in the first cycle after reset.
- `LAT`=1, `i_req`, `i_addr`=0x00400000, `mem_rdata`=0xDEADBEEF:
  - cycle 0: `i_gnt`=`mem_en`=1, `mem_addr`=0x00400000, `stall`=1;
  - cycle 1: `i_rvalid`=1, `i_rdata`=0xDEADBEEF, `stall`=0.
- `LAT`=1, load `d_addr`=0x1000 and fetch 0x00400004 both at cycle 0 -> `d_gnt` cycle 0, `d_rvalid` cycle 1, `i_gnt` cycle 2, `i_rvalid` cycle 3.
- Store `d_we`=1, `d_addr`=0x2000, `d_wdata`=0x12345678 -> cycle 0: `mem_we`=1, `mem_wdata`=0x12345678; cycle 1: `d_rvalid`=1, `d_rdata`=0.
- `LAT`=1, `STREAK_MAX`=4, `d_req` and `i_req` held continuously:
  - with macro: `d_gnt` at cycles 0, 2, 4, 6 and `i_gnt` at cycle 8;
  - without macro: no `i_gnt` in 20 cycles.
- `LAT`=3, fetch granted cycle 0, `reset` pulsed cycle 1 -> no `i_rvalid` at cycle 3. IDLE at cycle 2; re-grant possible at cycle 2.
